// File: rtl/phase_countdown_pkg.sv
// Shared types, widths and helpers for the two-phase countdown sequencer.
package phase_countdown_pkg;

  localparam int TIME_W = 6;
  localparam int BCD_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN_A,
    RUN_B
  } state_t;

  // A zero preset still gives a phase of one tick, so remain never loads 0 while running.
  function automatic logic [TIME_W-1:0] eff_preset(input logic [TIME_W-1:0] p);
    return (p == '0) ? TIME_W'(1) : p;
  endfunction

  // Binary to two-digit BCD for 0..63 by repeated subtraction of ten (at most six steps).
  function automatic logic [2*BCD_W-1:0] to_bcd(input logic [TIME_W-1:0] value);
    logic [TIME_W-1:0] rest;
    logic [BCD_W-1:0]  tens;
    rest = value;
    tens = '0;
    for (int i = 0; i < 6; i++) begin
      if (rest >= TIME_W'(10)) begin
        rest = rest - TIME_W'(10);
        tens = tens + BCD_W'(1);
      end
    end
    return {tens, rest[BCD_W-1:0]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles.
// The count holds while en is low, so a pause resumes exactly where it left off.
module tick_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..CLK_DIV-1 while enabled, wrapping after the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/phase_countdown.sv
// Two-phase countdown sequencer: alternates phase A and phase B forever,
// counting each phase down once per prescaler tick.
// Optional feature macro: PHASE_COUNTDOWN_BCD_EN compiles in the registered
// BCD converter; without it bcd_tens/bcd_ones are tied to zero.
module phase_countdown
  import phase_countdown_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] preset_a,
  input  logic [TIME_W-1:0] preset_b,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic              phase,
  output logic              running,
  output logic [TIME_W-1:0] remain,
  output logic              phase_done,
  output logic [BCD_W-1:0]  bcd_tens,
  output logic [BCD_W-1:0]  bcd_ones
);

  state_t            state;
  state_t            state_next;
  logic [TIME_W-1:0] remain_next;
  logic              phase_next;
  logic              done_next;
  logic              tick;
  logic              prescale_clr;
  logic              prescale_en;

  // The prescaler is held at zero in IDLE so every phase A load starts a fresh tick period.
  assign prescale_clr = (state == IDLE) || stop;
  assign prescale_en  = (state != IDLE) && !pause && !stop;

  tick_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (prescale_clr),
    .en  (prescale_en),
    .tick(tick)
  );

  // State and registered outputs; remain/phase/phase_done update together on each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remain     <= '0;
      phase      <= 1'b0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_next;
      remain     <= remain_next;
      phase      <= phase_next;
      phase_done <= done_next;
    end
  end

  // Next-state and next-value logic; stop overrides everything, tick is gated off by pause.
  always_comb begin
    state_next  = state;
    remain_next = remain;
    phase_next  = phase;
    done_next   = 1'b0;
    if (stop) begin
      state_next  = IDLE;
      remain_next = '0;
      phase_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          remain_next = '0;
          phase_next  = 1'b0;
          if (start) begin
            state_next  = RUN_A;
            remain_next = eff_preset(preset_a);
          end
        end
        RUN_A: begin
          if (tick) begin
            if (remain > TIME_W'(1)) begin
              remain_next = remain - TIME_W'(1);
            end else begin
              state_next  = RUN_B;
              remain_next = eff_preset(preset_b);
              phase_next  = 1'b1;
              done_next   = 1'b1;
            end
          end
        end
        RUN_B: begin
          if (tick) begin
            if (remain > TIME_W'(1)) begin
              remain_next = remain - TIME_W'(1);
            end else begin
              state_next  = RUN_A;
              remain_next = eff_preset(preset_a);
              phase_next  = 1'b0;
              done_next   = 1'b1;
            end
          end
        end
        default: begin
          state_next  = IDLE;
          remain_next = '0;
          phase_next  = 1'b0;
        end
      endcase
    end
  end

  // Status output decoded straight from the state.
  always_comb begin
    running = 1'b0;
    if (state == RUN_A || state == RUN_B) begin
      running = 1'b1;
    end
  end

`ifdef PHASE_COUNTDOWN_BCD_EN
  // Register the decimal digits of remain, one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_tens <= '0;
      bcd_ones <= '0;
    end else begin
      {bcd_tens, bcd_ones} <= to_bcd(remain);
    end
  end
`else
  assign bcd_tens = '0;
  assign bcd_ones = '0;
`endif

endmodule

// File: tb/tb_phase_countdown.sv
// Directed testbench for phase_countdown with CLK_DIV = 4.
module tb_phase_countdown;

  logic       clk;
  logic       rst;
  logic [5:0] preset_a;
  logic [5:0] preset_b;
  logic       start;
  logic       stop;
  logic       pause;
  logic       phase;
  logic       running;
  logic [5:0] remain;
  logic       phase_done;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;

  int compareCount;
  int mismatchCount;
  int donePulses;

  phase_countdown #(
    .CLK_DIV(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .preset_a  (preset_a),
    .preset_b  (preset_b),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .phase     (phase),
    .running   (running),
    .remain    (remain),
    .phase_done(phase_done),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Set the control and preset inputs; they are sampled at the next rising edge.
  task automatic applyStimulus(input logic s, input logic sp, input logic pa,
                               input logic [5:0] a, input logic [5:0] b);
    start    = s;
    stop     = sp;
    pause    = pa;
    preset_a = a;
    preset_b = b;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_running"}, int'(running), 0);
    checkOutput({tag, "_remain"}, int'(remain), 0);
    checkOutput({tag, "_phase"}, int'(phase), 0);
    checkOutput({tag, "_done"}, int'(phase_done), 0);
  endtask

  initial begin
    int expRemain [6];
    int expPhase  [6];
    compareCount  = 0;
    mismatchCount = 0;
    expRemain = '{3, 2, 1, 2, 1, 3};
    expPhase  = '{0, 0, 0, 1, 1, 0};

    // Reset values
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    stepCycles(2);
    rst = 1'b0;
    checkIdle("reset");
    checkOutput("reset_bcd_tens", int'(bcd_tens), 0);
    checkOutput("reset_bcd_ones", int'(bcd_ones), 0);

    // Basic sequence A=3, B=2: remain 3,2,1 | 2,1 | 3, a switch every 12/20 cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd3, 6'd2);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd3, 6'd2);
    checkOutput("seq_start_running", int'(running), 1);
    checkOutput("seq_start_remain", int'(remain), 3);
    donePulses = 0;
    for (int k = 1; k <= 20; k++) begin
      stepCycles(1);
      if (phase_done) donePulses++;
      checkOutput($sformatf("seq_remain_k%0d", k), int'(remain), expRemain[k/4]);
      checkOutput($sformatf("seq_phase_k%0d", k), int'(phase), expPhase[k/4]);
      checkOutput($sformatf("seq_done_k%0d", k), int'(phase_done),
                  ((k == 12) || (k == 20)) ? 1 : 0);
    end
    checkOutput("seq_done_pulses", donePulses, 2);

    // Zero preset treated as one tick: each phase lasts 4 cycles, remain stays 1
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 6'd1);
    stepCycles(1);
    checkIdle("zero_stop");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'd1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 6'd1);
    checkOutput("zero_start_remain", int'(remain), 1);
    for (int k = 1; k <= 12; k++) begin
      stepCycles(1);
      checkOutput($sformatf("zero_remain_k%0d", k), int'(remain), 1);
      checkOutput($sformatf("zero_phase_k%0d", k), int'(phase), (k / 4) % 2);
      checkOutput($sformatf("zero_done_k%0d", k), int'(phase_done), (k % 4 == 0) ? 1 : 0);
    end

    // Pause for 10 cycles at remain = 5 with the prescaler two counts in
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd7, 6'd3);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd7, 6'd3);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd7, 6'd3);
    stepCycles(10);
    checkOutput("pause_before_remain", int'(remain), 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd7, 6'd3);
    for (int k = 1; k <= 10; k++) begin
      stepCycles(1);
      checkOutput($sformatf("pause_remain_k%0d", k), int'(remain), 5);
      checkOutput($sformatf("pause_running_k%0d", k), int'(running), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd7, 6'd3);
    stepCycles(1);
    checkOutput("resume_remain_1", int'(remain), 5);
    stepCycles(1);
    checkOutput("resume_remain_2", int'(remain), 4);

    // Start and stop together from IDLE, then stop during phase B
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd2, 6'd2);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd2, 6'd2);
    stepCycles(1);
    checkIdle("startstop");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd2, 6'd2);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd2, 6'd2);
    stepCycles(8);
    checkOutput("runb_phase", int'(phase), 1);
    checkOutput("runb_remain", int'(remain), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd2, 6'd2);
    stepCycles(1);
    checkIdle("stop_in_b");

    // Reset mid-run at remain = 2, with start held high to show it is ignored while running
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd3, 6'd2);
    stepCycles(5);
    checkOutput("hold_start_remain", int'(remain), 2);
    checkOutput("hold_start_phase", int'(phase), 0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd3, 6'd2);
    stepCycles(1);
    checkIdle("mid_rst");
    stepCycles(1);
    checkOutput("mid_rst_bcd_tens", int'(bcd_tens), 0);
    checkOutput("mid_rst_bcd_ones", int'(bcd_ones), 0);
    rst = 1'b0;

    // BCD of a 20-tick preset, one cycle after load
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd20, 6'd5);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd20, 6'd5);
    checkOutput("bcd_load_remain", int'(remain), 20);
    checkOutput("bcd_lag_tens", int'(bcd_tens), 0);
    stepCycles(1);
`ifdef PHASE_COUNTDOWN_BCD_EN
    checkOutput("bcd_tens", int'(bcd_tens), 2);
    checkOutput("bcd_ones", int'(bcd_ones), 0);
`else
    checkOutput("bcd_tens_off", int'(bcd_tens), 0);
    checkOutput("bcd_ones_off", int'(bcd_ones), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
